// File: rtl/md_scale_seq.sv
// md_scale_seq: round-robin sequencer for one shared power-of-two scaling unit.
// A requested shift of any magnitude is split into steps of at most 3 bits.
// Each step goes through the external unit, one step per cycle, and the
// final value is returned over a valid/ready handshake.
//
// state | meaning
// IDLE  | arbitrate between requesters; accept one operation
// RUN   | one scaling step per cycle until the remaining shift is zero
// DONE  | result presented; held until the consumer takes it
module md_scale_seq #(
  parameter int N   = 32,
  parameter int SHW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N-1:0]   req0_f,
  input  logic [SHW-1:0] req0_sh,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N-1:0]   req1_f,
  input  logic [SHW-1:0] req1_sh,
  output logic [2:0]     md_c,
  output logic [N-1:0]   md_f,
  input  logic [N-1:0]   md_fs,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [N-1:0]   res_data,
  output logic           res_id,
  output logic           busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic signed [SHW-1:0] ONE   = SHW'(1);
  localparam logic signed [SHW-1:0] TWO   = SHW'(2);
  localparam logic signed [SHW-1:0] THREE = SHW'(3);

  state_t                state_q, state_d;
  logic [N-1:0]          acc_q, acc_d;
  logic signed [SHW-1:0] rem_q, rem_d, rem_step;
  logic                  id_q, id_d;
  logic                  last_q, last_d;
  logic                  grant0, grant1;
  logic [2:0]            step_c;

  // Register update; reset discards any in-flight operation.
  // last resets to 1 so requester 0 wins the first contended round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  // Decode the next step from the remaining shift: largest step first, a
  // zero remainder only occurs on the first step of a zero shift (pass).
  always_comb begin
    step_c   = 3'd3;
    rem_step = '0;
    if (rem_q >= THREE) begin
      step_c   = 3'd6;
      rem_step = rem_q - THREE;
    end else if (rem_q == TWO) begin
      step_c = 3'd5;
    end else if (rem_q == ONE) begin
      step_c = 3'd4;
    end else if (rem_q <= -THREE) begin
      step_c   = 3'd0;
      rem_step = rem_q + THREE;
    end else if (rem_q == -TWO) begin
      step_c = 3'd1;
    end else if (rem_q == -ONE) begin
      step_c = 3'd2;
    end
  end

  // Round-robin grant: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_q);
    grant1 = req1_valid & (~req0_valid | ~last_q);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (grant0) begin
          acc_d   = req0_f;
          rem_d   = $signed(req0_sh);
          id_d    = 1'b0;
          last_d  = 1'b0;
          state_d = S_RUN;
        end else if (grant1) begin
          acc_d   = req1_f;
          rem_d   = $signed(req1_sh);
          id_d    = 1'b1;
          last_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = md_fs;
        rem_d = rem_step;
        if (rem_step == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; the shared unit is parked on code 7 (zero) outside RUN.
  always_comb begin
    req0_ready = (state_q == S_IDLE) & grant0;
    req1_ready = (state_q == S_IDLE) & grant1;
    md_c       = (state_q == S_RUN) ? step_c : 3'd7;
    md_f       = (state_q == S_RUN) ? acc_q : '0;
    res_valid  = (state_q == S_DONE);
    res_data   = (state_q == S_DONE) ? acc_q : '0;
    res_id     = id_q;
    busy       = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_md_scale_seq.sv
// Self-checking bench for md_scale_seq: directed table, backpressure,
// randomized operations against a whole-shift reference, reset mid-RUN and
// contention ordering.
module tb_md_scale_seq;
  localparam int N   = 32;
  localparam int SHW = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0]   req0_f, req1_f, md_f, md_fs, res_data;
  logic [SHW-1:0] req0_sh, req1_sh;
  logic [2:0]     md_c;
  logic           res_valid, res_ready, res_id, busy;

  int n_pass  = 0;
  int n_total = 0;
  int codes_q[$];

  always #5 clk = ~clk;

  md_scale_seq #(.N(N), .SHW(SHW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_f(req0_f), .req0_sh(req0_sh),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_f(req1_f), .req1_sh(req1_sh),
    .md_c(md_c), .md_f(md_f), .md_fs(md_fs),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .busy(busy)
  );

  // Shared scaling unit
  logic signed [N-1:0] md_f_s;
  assign md_f_s = md_f;
  always_comb begin
    case (md_c)
      3'd0:    md_fs = md_f_s >>> 3;
      3'd1:    md_fs = md_f_s >>> 2;
      3'd2:    md_fs = md_f_s >>> 1;
      3'd3:    md_fs = md_f;
      3'd4:    md_fs = md_f << 1;
      3'd5:    md_fs = md_f << 2;
      3'd6:    md_fs = md_f << 3;
      default: md_fs = '0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Whole shift in one go: left wraps modulo 2^N, right is arithmetic.
  function automatic logic [31:0] ref_scale(input logic [31:0] f, input int sh);
    logic signed [31:0] fs;
    int n;
    fs = f;
    if (sh >= 0) return f << sh;
    n = -sh;
    if (n >= 32) return fs[31] ? 32'hFFFF_FFFF : 32'h0;
    return fs >>> n;
  endfunction

  function automatic int ref_steps(input int sh);
    int a;
    a = (sh < 0) ? -sh : sh;
    return (a == 0) ? 1 : (a + 2) / 3;
  endfunction

  // Entered and left at a negedge.
  task automatic do_op(input logic who, input logic [31:0] f, input int sh,
                       input logic [31:0] exp, input int hold, input string tag);
    int lat;
    codes_q.delete();
    if (who) begin
      req1_valid = 1'b1; req1_f = f; req1_sh = SHW'(sh);
    end else begin
      req0_valid = 1'b1; req0_f = f; req0_sh = SHW'(sh);
    end
    #1;
    check({tag, " ready"}, 32'({req1_ready, req0_ready}), who ? 32'd2 : 32'd1);
    check({tag, " idle md_c"}, 32'(md_c), 32'd7);
    check({tag, " idle md_f"}, md_f, 32'd0);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 100) begin
      codes_q.push_back(int'(md_c));
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, " latency"}, 32'(lat), 32'(ref_steps(sh)));
    check({tag, " data"}, res_data, exp);
    check({tag, " id"}, 32'(res_id), 32'(who));
    for (int i = 0; i < hold; i++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      check({tag, " hold valid"}, 32'(res_valid), 32'd1);
      check({tag, " hold data"}, res_data, exp);
      check({tag, " hold id"}, 32'(res_id), 32'(who));
      check({tag, " hold ready"}, 32'({req1_ready, req0_ready}), 32'd0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, " back idle"}, 32'({busy, res_valid}), 32'd0);
  endtask

  typedef struct {
    logic        who;
    logic [31:0] f;
    int          sh;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int exp_codes0[3];
    int exp_codes1[2];
    int cnt;
    logic who;
    logic [31:0] f;
    int sh;

    exp_codes0 = '{6, 6, 4};
    exp_codes1 = '{0, 1};

    vecs[0] = '{1'b0, 32'h0000_0005,  7, 32'h0000_0280};
    vecs[1] = '{1'b1, 32'hFFFF_FF00, -5, 32'hFFFF_FFF8};
    vecs[2] = '{1'b0, 32'h1234_5678,  0, 32'h1234_5678};
    vecs[3] = '{1'b1, 32'h0000_0001, 31, 32'h8000_0000};
    vecs[4] = '{1'b0, 32'h8000_0000, -32, 32'hFFFF_FFFF};
    vecs[5] = '{1'b1, 32'h7FFF_FFFF,  1, 32'hFFFF_FFFE};
    vecs[6] = '{1'b0, 32'h0000_0003, -1, 32'h0000_0001};
    vecs[7] = '{1'b1, 32'hFFFF_FFF9, -2, 32'hFFFF_FFFE};
    vecs[8] = '{1'b1, 32'h1234_5678, -32, 32'h0000_0000};
    vecs[9] = '{1'b0, 32'h0000_0003,  3, 32'h0000_0018};

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_f = '0; req1_f = '0; req0_sh = '0; req1_sh = '0;
    res_ready = 1'b0;
    #3;
    check("rst res_valid", 32'(res_valid), 32'd0);
    check("rst res_data", res_data, 32'd0);
    check("rst res_id", 32'(res_id), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst md_c", 32'(md_c), 32'd7);
    check("rst md_f", md_f, 32'd0);
    check("rst ready", 32'({req1_ready, req0_ready}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].who, vecs[i].f, vecs[i].sh, vecs[i].exp, 0, $sformatf("vec%0d", i));
      if (i == 0) begin
        check("vec0 steps", 32'(codes_q.size()), 32'd3);
        for (int k = 0; k < 3 && k < codes_q.size(); k++)
          check($sformatf("vec0 md_c[%0d]", k), 32'(codes_q[k]), 32'(exp_codes0[k]));
      end
      if (i == 1) begin
        check("vec1 steps", 32'(codes_q.size()), 32'd2);
        for (int k = 0; k < 2 && k < codes_q.size(); k++)
          check($sformatf("vec1 md_c[%0d]", k), 32'(codes_q[k]), 32'(exp_codes1[k]));
      end
      if (i == 2) begin
        check("vec2 steps", 32'(codes_q.size()), 32'd1);
        if (codes_q.size() > 0) check("vec2 md_c", 32'(codes_q[0]), 32'd3);
      end
    end

    do_op(1'b1, 32'hDEAD_BEEF, -4, ref_scale(32'hDEAD_BEEF, -4), 5, "bp");

    for (int i = 0; i < 30; i++) begin
      who = 1'($urandom_range(0, 1));
      f   = $urandom;
      sh  = int'($urandom_range(0, 63)) - 32;
      do_op(who, f, sh, ref_scale(f, sh), int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
    end

    // Reset in the second RUN cycle of a long operation
    req0_valid = 1'b1; req0_f = 32'h1; req0_sh = SHW'(31);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid rst res_valid", 32'(res_valid), 32'd0);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst md_c", 32'(md_c), 32'd7);
    check("mid rst md_f", md_f, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention: both valid continuously, result always taken
    req0_f = 32'h100; req0_sh = SHW'(1);
    req1_f = 32'h200; req1_sh = SHW'(-1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    res_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      while (!(req0_ready | req1_ready) && cnt < 50) begin
        @(negedge clk); #1; cnt++;
      end
      check($sformatf("cont%0d both ready", k), 32'(req0_ready & req1_ready), 32'd0);
      check($sformatf("cont%0d grant", k), 32'({req1_ready, req0_ready}), (k % 2) ? 32'd2 : 32'd1);
      @(negedge clk); #1;
      cnt = 0;
      while (!res_valid && cnt < 50) begin
        @(negedge clk); #1; cnt++;
      end
      check($sformatf("cont%0d res_id", k), 32'(res_id), 32'(k % 2));
      check($sformatf("cont%0d data", k), res_data, (k % 2) ? 32'h100 : 32'h200);
      @(negedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/md_scale_seq.md
Name: md_scale_seq

Overview:
- Sequencer and arbiter for one shared power-of-two scaling unit: a 3-bit code c selects >>>3, >>>2, >>>1, pass, <<<1, <<<2, <<<3 or zero, applied to a signed N-bit value f.
- Two requesters each submit an operand and a signed shift amount of any magnitude; the block grants one requester round-robin.
- It breaks the shift into steps of at most 3 bits, drives them through the shared unit one per cycle, and returns the result over a valid/ready handshake.

Parameters:
- N, 32, datapath width; must match the shared scaling unit.
- SHW, 6, width of the signed shift amount (range -2^(SHW-1) .. 2^(SHW-1)-1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_f  in  N  requester 0 signed operand.
- req0_sh  in  SHW  requester 0 signed shift (+ = left/multiply, - = right/divide).
- req1_valid, req1_ready, req1_f, req1_sh  same widths and meaning for requester 1.
- md_c  out  3  code to the shared scaling unit.
- md_f  out  N  operand to the shared scaling unit.
- md_fs  in  N  combinational result from the shared scaling unit.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_data  out  N  signed result.
- res_id  out  1  requester that owns res_data.
- busy  out  1  high in RUN or DONE.

Behaviour:
- State machine: IDLE, RUN, DONE. Registers: acc[N], rem[SHW], id, last.
- Reset (asynchronous, any state) forces:
  - state=IDLE, acc=0, rem=0, id=0, last=1.
  - Outputs: res_valid=0, res_data=0, res_id=0, busy=0, md_c=7, md_f=0, req ready outputs=0.
  - An in-flight operation is discarded; no partial result is ever presented.
- IDLE arbitration:
  - Only one requester valid: it is granted.
  - Both valid: the requester other than last is granted.
  - reqX_ready = (state==IDLE) & grantX; this is combinational from the valid inputs, and at most one ready is high.
  - ready is 0 in RUN and DONE.
- Accept: on the edge where reqX_valid & reqX_ready:
  - acc<=reqX_f, rem<=reqX_sh, id<=X, last<=X, state<=RUN.
  - Requesters must hold f and sh stable while valid is high.
- RUN: md_f=acc. Exactly one step per cycle, with acc<=md_fs and rem updated as follows:
  - rem>=3: md_c=6, rem-=3.
  - rem==2: md_c=5, rem=0.
  - rem==1: md_c=4, rem=0.
  - rem<=-3: md_c=0, rem+=3.
  - rem==-2: md_c=1, rem=0.
  - rem==-1: md_c=2, rem=0.
  - rem==0: md_c=3 (pass; only occurs on the first step, for a zero shift).
  - The state moves to DONE on the edge where the updated rem is 0.
- Step count and latency:
  - Steps = max(1, ceil(|sh|/3)).
  - res_valid rises after accept edge + steps edges.
- DONE:
  - res_valid=1, res_data=acc, res_id=id; held stable while res_ready=0.
  - On the edge with res_valid & res_ready: state<=IDLE, res_valid<=0.
  - No accept happens in the same cycle; minimum issue interval is steps+2 cycles.
- Outside RUN, md_c=7 and md_f=0, so the shared unit outputs 0.
- Arithmetic:
  - Right steps are arithmetic (sign-preserving); large negative shifts converge to 0 or -1.
  - Left steps wrap modulo 2^N with no saturation; bits shifted out are lost and the sign may flip.
- busy = (state!=IDLE).

Test Plan:
- Left shift, req0 only:
  - Stimulus: req0_f=5, req0_sh=7.
  - Response: md_c sequence 6,6,4 in RUN; res_data=0x00000280; res_id=0; res_valid 4 cycles after accept.
- Right shift, req1 only:
  - Stimulus: req1_f=0xFFFFFF00 (-256), req1_sh=-5.
  - Response: md_c 0,1; res_data=0xFFFFFFF8 (-8); res_id=1; latency 3.
- Zero shift:
  - Stimulus: req0_f=0x12345678, sh=0.
  - Response: one md_c=3 step; res_data=0x12345678; latency 2.
- Contention:
  - Stimulus: both valid continuously, res_ready=1, four operations.
  - Response: grant/res_id order 0,1,0,1; never both ready high.
- Backpressure:
  - Stimulus: res_ready=0 for 5 cycles in DONE.
  - Response: res_valid, res_data and res_id unchanged; both ready outputs 0; IDLE on the cycle after res_ready=1.
- Reset mid-RUN:
  - Stimulus: req0_sh=31, rst_n low on the 2nd RUN cycle.
  - Response: immediately res_valid=0, busy=0, md_c=7, md_f=0. After release, with both requesters valid, req0 is granted first.
